step_motor_sequencer: RTL and testbench

Generates the four coil-phase signals (AX, AY, BX, BY) for one two-phase stepper axis from a step-count / direction / rate command. One instance per axis (microscope X/Y/Z, syringe) sits directly upstream of the board-level phase pins. The H-bridge polarity inversion and pin mapping happen downstream, not here. Provides half/full stepping, a signed position count, graceful stop, and a latched driver-fault abort.

---
 rtl/step_motor_pkg.sv | 18 +
 rtl/step_rate_timer.sv | 34 +++
 rtl/step_motor_sequencer.sv | 162 ++++++++++++++++
 tb/tb_step_motor_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/step_motor_pkg.sv
// Shared types and constants for the two-phase stepper phase sequencer.
package step_motor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_e;

  localparam int MIN_PERIOD = 2;

  // Coil pattern per phase index, packed as {AX, AY, BX, BY}
  localparam logic [3:0] PHASE_TABLE [8] = '{
    4'b1000, 4'b1010, 4'b0010, 4'b0110,
    4'b0100, 4'b0101, 4'b0001, 4'b1001
  };

endpackage

// File: rtl/step_rate_timer.sv
// Loadable down-counter; tc flags the clock on which an enabled count sits at zero.
module step_rate_timer #(
  parameter int PER_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [PER_W-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  logic [PER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - PER_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = en && (count_q == '0);

endmodule

// File: rtl/step_motor_sequencer.sv
// Coil-phase sequencer for one stepper axis: half/full stepping, signed position,
// graceful stop and a latched driver-fault abort.
module step_motor_sequencer
  import step_motor_pkg::*;
#(
  parameter int STEPS_W = 16,
  parameter int PER_W   = 24,
  parameter int POS_W   = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    dir,
  input  logic                    half_step,
  input  logic [STEPS_W-1:0]      steps,
  input  logic [PER_W-1:0]        period,
  input  logic                    hold_en,
  input  logic                    stop,
  input  logic                    fault_n,
  input  logic                    clear_fault,
  output logic                    AX,
  output logic                    AY,
  output logic                    BX,
  output logic                    BY,
  output logic                    busy,
  output logic                    done,
  output logic                    fault_latched,
  output logic signed [POS_W-1:0] position,
  output logic [2:0]              phase_idx
);

  state_e                  state_q, state_d;
  logic                    sync1_q, sync2_q;
  logic                    dir_q, dir_d, half_q, half_d;
  logic [STEPS_W-1:0]      remain_q, remain_d;
  logic [PER_W-1:0]        per_q, per_d, per_eff;
  logic [2:0]              phase_q, phase_d;
  logic signed [POS_W-1:0] pos_q, pos_d;
  logic [3:0]              coil_q, coil_d;
  logic                    busy_q, busy_d, done_q, done_d, flt_q, flt_d;
  logic                    tmr_load, tmr_en, tmr_tc;
  logic [PER_W-1:0]        tmr_val;
  logic [1:0]              step_amt;

  assign per_eff = (period < PER_W'(MIN_PERIOD)) ? PER_W'(MIN_PERIOD) : period;
  assign tmr_en  = (state_q == RUN);

  // An even index in full-step mode takes a single half step to reach the two-coil (odd) positions
  assign step_amt = (half_q || !phase_q[0]) ? 2'd1 : 2'd2;

  step_rate_timer #(.PER_W(PER_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .tc       (tmr_tc)
  );

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    half_d   = half_q;
    remain_d = remain_q;
    per_d    = per_q;
    phase_d  = phase_q;
    pos_d    = pos_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = per_q - PER_W'(1);

    if (!sync2_q) begin
      state_d = FAULT;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            dir_d    = dir;
            half_d   = half_step;
            remain_d = steps;
            per_d    = per_eff;
            tmr_load = 1'b1;
            tmr_val  = per_eff - PER_W'(1);
            if (steps == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (stop) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (tmr_tc) begin
            phase_d  = dir_q ? phase_q + 3'(step_amt) : phase_q - 3'(step_amt);
            pos_d    = dir_q ? pos_q + POS_W'(step_amt) : pos_q - POS_W'(step_amt);
            remain_d = remain_q - STEPS_W'(1);
            tmr_load = 1'b1;
            if (remain_q == STEPS_W'(1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        FAULT: begin
          if (clear_fault) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == RUN);
    flt_d  = (state_d == FAULT);
    coil_d = ((state_d == RUN) || ((state_d == IDLE) && hold_en)) ? PHASE_TABLE[phase_d] : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= '0;
      pos_q   <= '0;
      coil_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      flt_q   <= 1'b0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pos_q   <= pos_d;
      coil_q  <= coil_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      flt_q   <= flt_d;
      sync1_q <= fault_n;
      sync2_q <= sync1_q;
    end
  end

  // Move parameters are only read while RUN, after a start has loaded them
  always_ff @(posedge clk) begin
    dir_q    <= dir_d;
    half_q   <= half_d;
    remain_q <= remain_d;
    per_q    <= per_d;
  end

  assign AX            = coil_q[3];
  assign AY            = coil_q[2];
  assign BX            = coil_q[1];
  assign BY            = coil_q[0];
  assign busy          = busy_q;
  assign done          = done_q;
  assign fault_latched = flt_q;
  assign position      = pos_q;
  assign phase_idx     = phase_q;

endmodule

// File: tb/tb_step_motor_sequencer.sv
// Bench for step_motor_sequencer: behavioural model compared every cycle, plus directed literal checks.
module tb_step_motor_sequencer;

  logic               clk = 1'b0;
  logic               reset, start, dir, half_step, hold_en, stop, fault_n, clear_fault;
  logic [15:0]        steps;
  logic [23:0]        period;
  logic               AX, AY, BX, BY, busy, done, fault_latched;
  logic signed [31:0] position;
  logic [2:0]         phase_idx;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  step_motor_sequencer #(.STEPS_W(16), .PER_W(24), .POS_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .dir           (dir),
    .half_step     (half_step),
    .steps         (steps),
    .period        (period),
    .hold_en       (hold_en),
    .stop          (stop),
    .fault_n       (fault_n),
    .clear_fault   (clear_fault),
    .AX            (AX),
    .AY            (AY),
    .BX            (BX),
    .BY            (BY),
    .busy          (busy),
    .done          (done),
    .fault_latched (fault_latched),
    .position      (position),
    .phase_idx     (phase_idx)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_FLT  = 2;

  int       m_mode, m_phase, m_pos, m_remain, m_pe, m_next;
  int       cyc = 0;
  bit       m_dir, m_half, m_done, m_live;
  bit       fn_d1 = 1'b1, fn_d2 = 1'b1;
  logic [3:0] m_coils;

  // Each coil is energised over three consecutive table indices
  function automatic logic [3:0] coils_for(input int i);
    coils_for = {(i == 7 || i <= 1), (i >= 3 && i <= 5), (i >= 1 && i <= 3), (i >= 5 && i <= 7)};
  endfunction

  always @(posedge clk) begin
    bit eff;
    int amt;
    cyc++;
    eff    = fn_d2;
    fn_d2  = fn_d1;
    fn_d1  = fault_n;
    m_done = 1'b0;
    if (reset) begin
      m_mode  = M_IDLE;
      m_phase = 0;
      m_pos   = 0;
      fn_d1   = 1'b1;
      fn_d2   = 1'b1;
      m_live  = 1'b1;
      m_coils = 4'b0000;
    end else begin
      if (!eff) begin
        m_mode = M_FLT;
      end else if (m_mode == M_IDLE) begin
        if (start) begin
          m_dir    = dir;
          m_half   = half_step;
          m_remain = int'(steps);
          m_pe     = (period < 2) ? 2 : int'(period);
          if (steps == 0) begin
            m_done = 1'b1;
          end else begin
            m_mode = M_RUN;
            m_next = cyc + m_pe;
          end
        end
      end else if (m_mode == M_RUN) begin
        if (stop) begin
          m_mode = M_IDLE;
          m_done = 1'b1;
        end else if (cyc == m_next) begin
          amt      = (m_half || (m_phase % 2 == 0)) ? 1 : 2;
          if (!m_dir) amt = -amt;
          m_phase  = (m_phase + amt + 8) % 8;
          m_pos    = m_pos + amt;
          m_remain = m_remain - 1;
          m_next   = m_next + m_pe;
          if (m_remain == 0) begin
            m_mode = M_IDLE;
            m_done = 1'b1;
          end
        end
      end else begin
        if (clear_fault) m_mode = M_IDLE;
      end
      m_coils = (m_mode == M_RUN || (m_mode == M_IDLE && hold_en)) ? coils_for(m_phase) : 4'b0000;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("coils",    int'({AX, AY, BX, BY}), int'(m_coils));
      chk("busy",     int'(busy),          int'(m_mode == M_RUN));
      chk("done",     int'(done),          int'(m_done));
      chk("fault",    int'(fault_latched), int'(m_mode == M_FLT));
      chk("position", int'(position),      m_pos);
      chk("phase",    int'(phase_idx),     m_phase);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // k counts negedges after the edge that accepts start (k=0 is the first one)
  task automatic run_move(input bit d, input bit h, input int s, input int p, input int ncyc,
                          input int stop_k, input int restart_k, input int fault_k,
                          output int first_k, output int done_k, output int flt_k);
    int ph0;
    first_k = -1;
    done_k  = -1;
    flt_k   = -1;
    @(negedge clk);
    dir       = d;
    half_step = h;
    steps     = 16'(s);
    period    = 24'(p);
    start     = 1'b1;
    ph0       = int'(phase_idx);
    for (int k = 0; k <= ncyc; k++) begin
      @(negedge clk);
      if (first_k < 0 && int'(phase_idx) != ph0) first_k = k;
      if (done_k < 0 && done) done_k = k;
      if (flt_k < 0 && fault_latched) flt_k = k;
      start = (k == restart_k);
      stop  = (k == stop_k);
      if (fault_k >= 0 && k >= fault_k) fault_n = 1'b0;
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    int fk, dk, flk, p0;
    reset = 1'b1; start = 1'b0; dir = 1'b0; half_step = 1'b0; hold_en = 1'b1;
    stop = 1'b0; fault_n = 1'b1; clear_fault = 1'b0; steps = '0; period = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_position", int'(position), 0);
    chk("rst_phase",    int'(phase_idx), 0);
    chk("rst_busy",     int'(busy), 0);
    chk("rst_fault",    int'(fault_latched), 0);

    // Half-step forward, 4 steps, period 10
    run_move(1'b1, 1'b1, 4, 10, 45, -1, -1, -1, fk, dk, flk);
    chk("hs_first_k", fk, 10);
    chk("hs_done_k",  dk, 40);
    chk("hs_position", int'(position), 4);
    chk("hs_phase",    int'(phase_idx), 4);
    chk("hs_model_pos", m_pos, 4);

    // Full-step reverse from index 0: 7,5,3
    do_reset();
    run_move(1'b0, 1'b0, 3, 5, 20, -1, -1, -1, fk, dk, flk);
    chk("fs_first_k",  fk, 5);
    chk("fs_done_k",   dk, 15);
    chk("fs_position", int'(position), -5);
    chk("fs_phase",    int'(phase_idx), 3);
    chk("fs_coils",    int'({AX, AY, BX, BY}), 6);
    chk("fs_model_phase", m_phase, 3);

    // Stop after the 10th step, with a start pulsed mid-move
    do_reset();
    run_move(1'b1, 1'b1, 100, 4, 50, 40, 5, -1, fk, dk, flk);
    chk("stop_done_k",  dk, 41);
    chk("stop_position", int'(position), 10);
    chk("stop_busy",     int'(busy), 0);

    // Fault mid-move, then clear
    do_reset();
    run_move(1'b1, 1'b1, 50, 3, 20, -1, -1, 10, fk, dk, flk);
    chk("flt_enter_k",  flk, 13);
    chk("flt_no_done",  dk, -1);
    chk("flt_position", int'(position), 4);
    chk("flt_coils",    int'({AX, AY, BX, BY}), 0);
    @(negedge clk);
    clear_fault = 1'b1;
    repeat (4) @(negedge clk);
    chk("flt_held_low", int'(fault_latched), 1);
    fault_n = 1'b1;
    repeat (5) @(negedge clk);
    clear_fault = 1'b0;
    chk("flt_cleared",  int'(fault_latched), 0);
    chk("flt_pos_kept", int'(position), 4);

    // Zero-length move
    p0 = int'(position);
    run_move(1'b1, 1'b1, 0, 5, 3, -1, -1, -1, fk, dk, flk);
    chk("zero_done_k",   dk, 0);
    chk("zero_no_move",  fk, -1);
    chk("zero_position", int'(position), p0);

    // Period 0 and 1 clamp to 2
    run_move(1'b1, 1'b1, 3, 0, 8, -1, -1, -1, fk, dk, flk);
    chk("p0_first_k", fk, 2);
    chk("p0_done_k",  dk, 6);
    run_move(1'b0, 1'b1, 3, 1, 8, -1, -1, -1, fk, dk, flk);
    chk("p1_first_k", fk, 2);
    chk("p1_done_k",  dk, 6);

    // hold_en=0 de-energises the coils while idle
    @(negedge clk);
    hold_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("nohold_coils", int'({AX, AY, BX, BY}), 0);
    hold_en = 1'b1;

    // Reverse wrap from index 0
    do_reset();
    run_move(1'b0, 1'b1, 1, 2, 4, -1, -1, -1, fk, dk, flk);
    chk("wrap_phase",    int'(phase_idx), 7);
    chk("wrap_position", int'(position), -1);

    // Randomised traffic against the model
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      reset       = ($urandom_range(0, 999) == 0);
      start       = ($urandom_range(0, 5) == 0);
      stop        = ($urandom_range(0, 39) == 0);
      clear_fault = ($urandom_range(0, 3) == 0);
      if (fault_n) fault_n = ($urandom_range(0, 299) != 0);
      else         fault_n = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 49) == 0) hold_en = ~hold_en;
      dir       = 1'($urandom);
      half_step = 1'($urandom);
      steps     = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
      period    = 24'($urandom_range(0, 7));
    end
    @(negedge clk);
    reset = 1'b0; start = 1'b0; stop = 1'b0; clear_fault = 1'b0; fault_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
